// File: rtl/coldstorage_scheduler.sv
// coldstorage_scheduler: periodic sensor poll and report sequencer.
// Every POLL_TICKS cycles (or on force_poll) it runs one sensor measurement.
// A good sample is reported to the UART, and then the LCD is refreshed.
// A timed-out measurement skips the UART and only refreshes the LCD.
// Optional feature macro: SCHED_RETRY_EN. When it is defined, the first
// timeout of a poll is retried once before it is treated as a fault.
// o_state exposes the FSM encoding for observation.
module coldstorage_scheduler #(
    parameter int unsigned POLL_TICKS    = 200000000,
    parameter int unsigned TIMEOUT_TICKS = 50000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_force_poll,
    output logic       o_dht_en,
    input  logic       i_dht_data_ready,
    input  logic [7:0] i_dht_temperature,
    input  logic [7:0] i_dht_humidity,
    output logic       o_uart_start,
    input  logic       i_uart_busy,
    output logic       o_lcd_en,
    input  logic       i_lcd_busy,
    output logic [7:0] o_temperature,
    output logic [7:0] o_humidity,
    output logic       o_data_valid,
    output logic       o_sensor_fault,
    output logic [7:0] o_fault_count,
    output logic [2:0] o_state
);

    // Handshake with the UART and LCD writers: a request strobe (uart_start or
    // lcd_en) is raised for one cycle, and only when the matching busy is low.
    // The job counts as finished once busy has been seen high and then low.
    // If busy never rises within 4 wait cycles, the job also counts as finished,
    // because the writer completed it too fast to be observed.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MEASURE   = 3'd1,
        S_UART_REQ  = 3'd2,
        S_UART_WAIT = 3'd3,
        S_LCD_REQ   = 3'd4,
        S_LCD_WAIT  = 3'd5,
        S_RETRY     = 3'd6
    } state_t;

    localparam logic [31:0] POLL_LAST = 32'(POLL_TICKS - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_TICKS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_period;
    logic [31:0] r_tcnt;
    logic        r_pending;
    logic        r_seen;
    logic [1:0]  r_wcnt;
    logic        r_retried;

    logic w_poll_due;
    logic w_poll_req;
    logic w_busy;
    logic w_wait_done;
    logic w_meas_ok;
    logic w_meas_to;
    logic w_fault;
    logic w_meas_entry;

    assign w_poll_due   = (r_period == POLL_LAST);
    assign w_poll_req   = w_poll_due | i_force_poll | r_pending;
    assign w_busy       = (r_state == S_UART_REQ || r_state == S_UART_WAIT) ? i_uart_busy : i_lcd_busy;
    assign w_wait_done  = !w_busy && (r_seen || r_wcnt == 2'd3);
    assign w_meas_ok    = (r_state == S_MEASURE) && i_dht_data_ready;
    assign w_meas_to    = (r_state == S_MEASURE) && !i_dht_data_ready && (r_tcnt == TO_LAST);
    assign w_meas_entry = (w_next == S_MEASURE) && (r_state != S_MEASURE);

`ifdef SCHED_RETRY_EN
    assign w_fault = w_meas_to && r_retried;
`else
    assign w_fault = w_meas_to;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_poll_req) w_next = S_MEASURE;
            S_MEASURE: begin
                if (w_meas_ok)      w_next = S_UART_REQ;
                else if (w_fault)   w_next = S_LCD_REQ;
`ifdef SCHED_RETRY_EN
                else if (w_meas_to) w_next = S_RETRY;
`endif
            end
`ifdef SCHED_RETRY_EN
            S_RETRY:     w_next = S_MEASURE;
`endif
            S_UART_REQ:  if (!i_uart_busy) w_next = S_UART_WAIT;
            S_UART_WAIT: if (w_wait_done)  w_next = S_LCD_REQ;
            S_LCD_REQ:   if (!i_lcd_busy)  w_next = S_LCD_WAIT;
            S_LCD_WAIT:  if (w_wait_done)  w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Output decode; request strobes are gated by busy, so each lasts one cycle
    always_comb begin
        o_dht_en     = 1'b0;
        o_uart_start = 1'b0;
        o_lcd_en     = 1'b0;
        o_state      = r_state;
        case (r_state)
            S_MEASURE:  o_dht_en     = 1'b1;
            S_UART_REQ: o_uart_start = !i_uart_busy;
            S_LCD_REQ:  o_lcd_en     = !i_lcd_busy;
            default:    ;
        endcase
    end

    // Free-running period counter, restarted whenever MEASURE is entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          r_period <= '0;
        else if (w_meas_entry) r_period <= '0;
        else                   r_period <= r_period + 32'd1;
    end

    // Poll requests arriving outside IDLE merge into one pending poll
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          r_pending <= 1'b0;
        else if (r_state == S_IDLE)            r_pending <= 1'b0;
        else if (i_force_poll || w_poll_due)   r_pending <= 1'b1;
    end

    // Measurement timeout counter, zero outside MEASURE so each entry starts fresh
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  r_tcnt <= '0;
        else if (r_state != S_MEASURE) r_tcnt <= '0;
        else                           r_tcnt <= r_tcnt + 32'd1;
    end

    // Busy tracking for the UART/LCD wait states
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seen <= 1'b0;
            r_wcnt <= 2'd0;
        end else if (r_state == S_UART_WAIT || r_state == S_LCD_WAIT) begin
            if (w_busy)           r_seen <= 1'b1;
            if (r_wcnt != 2'd3)   r_wcnt <= r_wcnt + 2'd1;
        end else begin
            r_seen <= 1'b0;
            r_wcnt <= 2'd0;
        end
    end

`ifdef SCHED_RETRY_EN
    // Remembers that this poll has already used its single retry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_retried <= 1'b0;
        else if (r_state == S_IDLE)  r_retried <= 1'b0;
        else if (r_state == S_RETRY) r_retried <= 1'b1;
    end
`else
    assign r_retried = 1'b0;
`endif

    // Sample and fault registers; a fault leaves the last good sample untouched
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_temperature  <= 8'h00;
            o_humidity     <= 8'h00;
            o_data_valid   <= 1'b0;
            o_sensor_fault <= 1'b0;
            o_fault_count  <= 8'h00;
        end else if (w_meas_ok) begin
            o_temperature  <= i_dht_temperature;
            o_humidity     <= i_dht_humidity;
            o_data_valid   <= 1'b1;
            o_sensor_fault <= 1'b0;
        end else if (w_fault) begin
            o_sensor_fault <= 1'b1;
            if (o_fault_count != 8'hFF) o_fault_count <= o_fault_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_coldstorage_scheduler.sv
// Directed testbench for coldstorage_scheduler (POLL_TICKS=100, TIMEOUT_TICKS=20).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_coldstorage_scheduler;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_UART_REQ = 3'd2;
  localparam logic [2:0] ST_RETRY    = 3'd6;

`ifdef SCHED_RETRY_EN
  localparam int EXP_HI    = 40;
  localparam int EXP_RISES = 2;
  localparam int EXP_GAP   = 1;
`else
  localparam int EXP_HI    = 20;
  localparam int EXP_RISES = 1;
  localparam int EXP_GAP   = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       force_poll = 1'b0;
  logic       dht_en;
  logic       dht_ready = 1'b0;
  logic [7:0] dht_t = 8'h00;
  logic [7:0] dht_h = 8'h00;
  logic       uart_start;
  logic       uart_busy = 1'b0;
  logic       lcd_en;
  logic       lcd_busy = 1'b0;
  logic [7:0] temperature;
  logic [7:0] humidity;
  logic       data_valid;
  logic       sensor_fault;
  logic [7:0] fault_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  coldstorage_scheduler #(.POLL_TICKS(100), .TIMEOUT_TICKS(20)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_force_poll      (force_poll),
    .o_dht_en          (dht_en),
    .i_dht_data_ready  (dht_ready),
    .i_dht_temperature (dht_t),
    .i_dht_humidity    (dht_h),
    .o_uart_start      (uart_start),
    .i_uart_busy       (uart_busy),
    .o_lcd_en          (lcd_en),
    .i_lcd_busy        (lcd_busy),
    .o_temperature     (temperature),
    .o_humidity        (humidity),
    .o_data_valid      (data_valid),
    .o_sensor_fault    (sensor_fault),
    .o_fault_count     (fault_count),
    .o_state           (state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] t;
    logic [7:0] h;
    int         delay;
    logic [7:0] exp_t;
    logic [7:0] exp_h;
    logic [7:0] exp_fcnt;
    int         exp_lcd_gap;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // step until IDLE, counting request strobes along the way
  task automatic wait_idle(output int lcds, output int uarts);
    lcds = 0;
    uarts = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (state == ST_IDLE) break;
      if (lcd_en) lcds++;
      if (uart_start) uarts++;
    end
    chk("reach_idle", state, ST_IDLE);
  endtask

  // step until dht_en rises, returns the number of steps taken
  task automatic wait_dht(output int n);
    n = 0;
    while (!dht_en && n < 400) begin
      step();
      n++;
    end
  endtask

  int n, hi, rises, gaps, lcds, uarts, early, c0, k, run;
  logic prev;

  initial begin
    vecs[0] = '{t: 8'h19, h: 8'h32, delay: 10, exp_t: 8'h19, exp_h: 8'h32, exp_fcnt: 8'd1, exp_lcd_gap: 5};
    vecs[1] = '{t: 8'h00, h: 8'hFF, delay: 0,  exp_t: 8'h00, exp_h: 8'hFF, exp_fcnt: 8'd1, exp_lcd_gap: 5};
    vecs[2] = '{t: 8'hFF, h: 8'h00, delay: 19, exp_t: 8'hFF, exp_h: 8'h00, exp_fcnt: 8'd1, exp_lcd_gap: 5};
    vecs[3] = '{t: 8'hA5, h: 8'h5A, delay: 3,  exp_t: 8'hA5, exp_h: 8'h5A, exp_fcnt: 8'd1, exp_lcd_gap: 5};

    // reset state
    #3 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_state", state, ST_IDLE);
    chk("rst_dht_en", dht_en, 0);
    chk("rst_uart_start", uart_start, 0);
    chk("rst_lcd_en", lcd_en, 0);
    chk("rst_temp", temperature, 0);
    chk("rst_hum", humidity, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_fault", sensor_fault, 0);
    chk("rst_fcnt", fault_count, 0);

    // first poll after release, with a silent sensor
    rst_n = 1'b1;
    wait_dht(n);
    chk("first_poll_latency", n, 100);
    hi = 1; rises = 1; gaps = 0; lcds = 0; uarts = 0; prev = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (state == ST_IDLE) break;
      if (dht_en) begin
        hi++;
        if (!prev) rises++;
      end
      if (state == ST_RETRY) gaps++;
      if (lcd_en) lcds++;
      if (uart_start) uarts++;
      prev = dht_en;
    end
    chk("silent_dht_high", hi, EXP_HI);
    chk("silent_dht_rises", rises, EXP_RISES);
    chk("silent_retry_gap", gaps, EXP_GAP);
    chk("silent_fault", sensor_fault, 1);
    chk("silent_fcnt", fault_count, 1);
    chk("silent_uart", uarts, 0);
    chk("silent_lcd", lcds, 1);
    chk("silent_valid", data_valid, 0);
    chk("silent_idle", state, ST_IDLE);

    // table-driven good polls
    for (int i = 0; i < 4; i++) begin
      force_poll = 1'b1;
      step();
      chk("row_dht_on", dht_en, 1);
      force_poll = 1'b0;
      repeat (vecs[i].delay) step();
      dht_t = vecs[i].t;
      dht_h = vecs[i].h;
      dht_ready = 1'b1;
      step();
      dht_ready = 1'b0;
      dht_t = 8'hEE;
      dht_h = 8'hEE;
      chk("row_uart_start", uart_start, 1);
      chk("row_dht_off", dht_en, 0);
      chk("row_temp", temperature, vecs[i].exp_t);
      chk("row_hum", humidity, vecs[i].exp_h);
      chk("row_valid", data_valid, 1);
      chk("row_fault", sensor_fault, 0);
      chk("row_fcnt", fault_count, vecs[i].exp_fcnt);
      n = 0;
      while (!lcd_en && n < 50) begin
        step();
        n++;
      end
      chk("row_lcd_gap", n, vecs[i].exp_lcd_gap);
      wait_idle(lcds, uarts);
      chk("row_extra_lcd", lcds, 0);
      chk("row_extra_uart", uarts, 0);
    end

    // ready pulse while IDLE is ignored
    dht_t = 8'h77;
    dht_h = 8'h77;
    dht_ready = 1'b1;
    step();
    dht_ready = 1'b0;
    chk("idle_ready_state", state, ST_IDLE);
    chk("idle_ready_temp", temperature, 8'hA5);
    chk("idle_ready_hum", humidity, 8'h5A);

    // UART busy for 50 cycles after ready, then a visible busy window in UART_WAIT
    force_poll = 1'b1;
    step();
    force_poll = 1'b0;
    repeat (5) step();
    dht_t = 8'h2C;
    dht_h = 8'h41;
    dht_ready = 1'b1;
    uart_busy = 1'b1;
    step();
    dht_ready = 1'b0;
    early = 0;
    for (int i = 0; i < 50; i++) begin
      if (uart_start) early++;
      if (i < 49) step();
    end
    chk("busy_no_start", early, 0);
    chk("busy_hold_state", state, ST_UART_REQ);
    chk("busy_sample_temp", temperature, 8'h2C);
    uart_busy = 1'b0;
    #1;
    chk("busy_release_start", uart_start, 1);
    step();
    chk("busy_start_single", uart_start, 0);
    uart_busy = 1'b1;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (lcd_en) early++;
    end
    uart_busy = 1'b0;
    chk("busy_no_early_lcd", early, 0);
    step();
    chk("busy_lcd_after_fall", lcd_en, 1);
    wait_idle(lcds, uarts);
    chk("busy_extra_uart", uarts, 0);

    // force_poll during UART_WAIT is served right after the report
    force_poll = 1'b1;
    step();
    force_poll = 1'b0;
    repeat (2) step();
    dht_ready = 1'b1;
    step();
    dht_ready = 1'b0;
    chk("fp_uart_start", uart_start, 1);
    step();
    force_poll = 1'b1;
    step();
    force_poll = 1'b0;
    wait_idle(lcds, uarts);
    chk("fp_lcd_count", lcds, 1);
    chk("fp_idle_dht", dht_en, 0);
    step();
    chk("fp_pending_start", dht_en, 1);
    c0 = cyc;
    step();
    dht_ready = 1'b1;
    step();
    dht_ready = 1'b0;
    wait_idle(lcds, uarts);
    early = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dht_en) early++;
    end
    chk("fp_no_second_poll", early, 0);

    // force_poll in the same cycle as poll_due gives one poll only
    for (int i = 0; i < 200 && cyc < c0 + 99; i++) step();
    chk("due_idle_before", dht_en, 0);
    force_poll = 1'b1;
    step();
    force_poll = 1'b0;
    chk("due_poll_start", dht_en, 1);
    dht_ready = 1'b1;
    step();
    dht_ready = 1'b0;
    wait_idle(lcds, uarts);
    early = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dht_en) early++;
    end
    chk("due_single_poll", early, 0);

    // asynchronous reset in the middle of MEASURE
    force_poll = 1'b1;
    step();
    force_poll = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dht", dht_en, 0);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_temp", temperature, 0);
    chk("mid_rst_state", state, ST_IDLE);
    step();
    rst_n = 1'b1;
    wait_dht(n);
    chk("mid_rst_latency", n, 100);
    chk("mid_rst_fcnt", fault_count, 0);
    step();
    dht_t = 8'h3C;
    dht_h = 8'h46;
    dht_ready = 1'b1;
    step();
    dht_ready = 1'b0;
    wait_idle(lcds, uarts);
    chk("mid_rst_temp_new", temperature, 8'h3C);

    // 300 back-to-back timeouts saturate the fault counter
    force_poll = 1'b1;
    k = 0;
    for (int i = 0; i < 30000; i++) begin
      step();
      if (lcd_en) begin
        k++;
        if (k == 254) chk("sat_254", fault_count, 254);
        if (k == 255) chk("sat_255", fault_count, 255);
        if (k == 300) break;
      end
    end
    force_poll = 1'b0;
    chk("sat_polls", k, 300);
    run = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (state == ST_IDLE) run++;
      else run = 0;
      if (run == 3) break;
    end
    chk("sat_settled", run, 3);
    chk("sat_fcnt", fault_count, 255);
    chk("sat_fault", sensor_fault, 1);
    chk("sat_valid_held", data_valid, 1);
    chk("sat_temp_held", temperature, 8'h3C);
    chk("sat_hum_held", humidity, 8'h46);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coldstorage_scheduler.md
COLDSTORAGE_SCHEDULER -- requirements
Module: coldstorage_scheduler

Interface
REQ-001 Parameter POLL_TICKS, default 200000000, clk cycles between poll starts (2 s at 100 MHz); legal range 16..2^32-1.
REQ-002 Parameter TIMEOUT_TICKS, default 50000000, clk cycles allowed per sensor measurement; must be less than POLL_TICKS.
REQ-003 clk  input  1  100 MHz system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 force_poll  input  1  level or pulse; requests an immediate poll.
REQ-006 dht_en  output  1  high while a sensor measurement is in progress.
REQ-007 dht_data_ready  input  1  one-cycle pulse from the sensor reader.
REQ-008 dht_temperature, dht_humidity  input  8 each  sensor values, valid in the dht_data_ready cycle.
REQ-009 uart_start  output  1  one-cycle report request; uart_busy  input  1  transmitter active.
REQ-010 lcd_en  output  1  one-cycle refresh request; lcd_busy  input  1  LCD writer active.
REQ-011 temperature, humidity  output  8 each  last good sample; data_valid  output  1  at least one good sample held.
REQ-012 sensor_fault  output  1  last poll timed out; fault_count  output  8  timeouts since reset, saturating.

Function
REQ-013 FSM states: IDLE, MEASURE, UART_REQ, UART_WAIT, LCD_REQ, LCD_WAIT.
REQ-014 Period counter: 32-bit, free-running; cleared at every MEASURE entry; poll_due when the counter equals POLL_TICKS-1.
REQ-015 IDLE -> MEASURE on poll_due or force_poll; simultaneous events produce one poll only.
REQ-016 force_poll outside IDLE: latched and served on the next IDLE cycle; further requests are merged.
REQ-017 MEASURE: dht_en=1; timeout counter cleared on entry and incremented each cycle.
REQ-018 MEASURE with dht_data_ready: latch both values the same cycle; data_valid=1; sensor_fault=0; next state UART_REQ.
REQ-019 MEASURE with timeout counter = TIMEOUT_TICKS-1 and no ready pulse: sensor_fault=1; fault_count+1, saturating at 255; outputs hold; next state LCD_REQ.
REQ-020 A ready pulse in the timeout cycle counts as success (ready wins).
REQ-021 dht_en=0 in the cycle after leaving MEASURE.
REQ-022 dht_data_ready outside MEASURE: ignored.
REQ-023 UART_REQ: waits while uart_busy=1; when uart_busy=0, uart_start=1 for exactly one cycle -> UART_WAIT.
REQ-024 UART_WAIT: stays until uart_busy has been seen high and then low, or 4 cycles pass with busy never high -> LCD_REQ.
REQ-025 LCD_REQ/LCD_WAIT: same rules as REQ-023/024, using lcd_busy and lcd_en -> IDLE.
REQ-026 Latency: from a ready pulse to uart_start is 1 cycle when the UART is idle.
REQ-027 The period counter keeps running during the report; a poll_due reached outside IDLE is latched like force_poll.

Reset
REQ-028 On rst_n low: state=IDLE and all counters=0.
REQ-029 Reset values: dht_en, uart_start, lcd_en, data_valid, sensor_fault = 0; temperature, humidity, fault_count = 8'h00.
REQ-030 Reset asserted mid-poll or mid-handshake aborts at once with no pulse completion.
REQ-031 After reset release, the first poll occurs after POLL_TICKS cycles unless force_poll is asserted.

Configuration
REQ-032 Macro SCHED_RETRY_EN defined: the first timeout of a poll re-enters MEASURE with dht_en low for 1 cycle and the timeout counter cleared; only a second timeout is handled as a fault (REQ-019).
REQ-033 SCHED_RETRY_EN undefined: a single timeout is handled as a fault; no retry logic is synthesised.

Verification (POLL_TICKS=100, TIMEOUT_TICKS=20)
REQ-034 Normal poll: ready pulse 10 cycles after dht_en with T=8'h19, H=8'h32, busy lines held low.
- Required: temperature=8'h19, humidity=8'h32, data_valid=1.
- Required: uart_start one cycle after ready, then one lcd_en pulse, then IDLE.
REQ-035 Sensor silent, macro undefined: dht_en high for exactly 20 cycles, then sensor_fault=1, fault_count=1, no uart_start, one lcd_en pulse.
- With the macro defined: dht_en high 20 cycles, low 1, high 20, then the fault.
REQ-036 uart_busy held high for 50 cycles after ready: uart_start is delayed until busy falls, then is a single-cycle pulse; lcd_en follows only after busy has gone high and then low.
REQ-037 force_poll asserted during UART_WAIT: after LCD_WAIT completes, exactly one new MEASURE starts on the cycle after returning to IDLE.
- force_poll together with poll_due: one poll only.
REQ-038 rst_n low for 1 cycle in the middle of MEASURE: all outputs return to reset values asynchronously; the next poll occurs 100 cycles after release.
REQ-039 Saturation: 300 consecutive timeouts leave fault_count=255.
